// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The control unit decodes funct into op_e; the unit sequences with state_e.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  function automatic logic is_div_op(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// Shared shift register for shift-add multiply and restoring divide on magnitudes.
// acc holds {upper partial (W+1 bits), lower word}: product halves or {remainder, quotient}.
module mult_div_datapath #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W:0]   a_mag,
  input  logic [W:0]   b_mag,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  logic [2*W:0] acc_q, acc_d;
  logic [W:0]   opnd_q, opnd_d;
  logic [W+1:0] mul_sum_s;
  logic [W+1:0] div_trial_s;

  // One iteration of the selected algorithm, or a fresh operand load.
  always_comb begin
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    mul_sum_s   = {1'b0, acc_q[2*W:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+2){1'b0}});
    div_trial_s = {1'b0, acc_q[2*W-1:W-1]} - {1'b0, opnd_q};
    if (load) begin
      acc_d  = {{W{1'b0}}, a_mag};
      opnd_d = b_mag;
    end else if (step) begin
      if (is_div) begin
        // A borrow out of the trial subtraction means the divisor did not fit.
        if (div_trial_s[W+1]) begin
          acc_d = {acc_q[2*W-1:0], 1'b0};
        end else begin
          acc_d = {div_trial_s[W:0], acc_q[W-2:0], 1'b1};
        end
      end else begin
        acc_d = {mul_sum_s, acc_q[W-1:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign res_hi = acc_q[2*W-1:W];
  assign res_lo = acc_q[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Sequencer, sign handling and MTHI/MTLO writes; the iterations live in mult_div_datapath.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [W-1:0]    a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d, div0_q, div0_d;
  logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  op_e             op_in_s;
  logic            a_neg_s, b_neg_s, load_s, step_s, div_op_s, neg_res_s;
  logic [W:0]      a_mag_s, b_mag_s;
  logic [W-1:0]    res_hi_s, res_lo_s;
  logic [2*W-1:0]  prod_s;

  assign op_in_s  = op_e'(op);
  assign a_neg_s  = is_signed_op(op_in_s) & A[W-1];
  assign b_neg_s  = is_signed_op(op_in_s) & B[W-1];
  // Sign-extend before negating so that the most negative value yields 2^(W-1).
  assign a_mag_s  = a_neg_s ? ({(W+1){1'b0}} - {1'b1, A}) : {1'b0, A};
  assign b_mag_s  = b_neg_s ? ({(W+1){1'b0}} - {1'b1, B}) : {1'b0, B};
  assign load_s   = (state_q == ST_IDLE) && start;
  assign step_s   = (state_q == ST_RUN);
  assign div_op_s = is_div_op(op_q);
  assign neg_res_s = neg_a_q ^ neg_b_q;
  assign prod_s   = {res_hi_s, res_lo_s};

  mult_div_datapath #(.W(W)) u_datapath (
    .clk    (clk),
    .rst_n  (reset),
    .load   (load_s),
    .step   (step_s),
    .is_div (div_op_s),
    .a_mag  (a_mag_s),
    .b_mag  (b_mag_s),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  // Sequencer next state and operand capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div0_d  = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_in_s;
          a_d     = A;
          neg_a_d = a_neg_s;
          neg_b_d = b_neg_s;
          cnt_d   = '0;
          div0_d  = is_div_op(op_in_s) && (B == '0);
          state_d = (is_div_op(op_in_s) && (B == '0)) ? ST_FINISH : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FINISH;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FINISH);
    dbz_d  = (state_q == ST_FINISH) && div0_q;
  end

  // HI/LO update: sign-corrected result on the FINISH edge, MTHI/MTLO only when idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == ST_FINISH) begin
      if (div0_q) begin
        hi_d = a_q;
        lo_d = '1;
      end else if (div_op_s) begin
        lo_d = neg_res_s ? -res_lo_s : res_lo_s;
        hi_d = neg_a_q ? -res_hi_s : res_hi_s;
      end else begin
        {hi_d, lo_d} = neg_res_s ? -prod_s : prod_s;
      end
    end else if ((state_q == ST_IDLE) && !start) begin
      hi_d = hi_we ? wdata : hi_q;
      lo_d = lo_we ? wdata : lo_q;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed MIPS cases, random ops against
// an arithmetic reference model, abort-by-reset and HI/LO write/handshake rules.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a_in), .B(b_in),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on 64-bit values.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, up;
    ed = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = 32'd0;
    el = 32'd0;
    case (o)
      2'b00: begin q = sa * sb; eh = q[63:32]; el = q[31:0]; end
      2'b01: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          ed = 1'b1; eh = a; el = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    else if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
    else return $urandom;
  endfunction

  // Launch one op from the current negedge and check its result in the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] eh, el;
    logic ed;
    int cyc, exp_lat;
    model(o, a, b, eh, el, ed);
    exp_lat = ed ? 2 : 34;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    cyc = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy); end
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat); end
    if (done === 1'b1) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done: got %b expected 0", name, busy); end
      checks++;
      if (hi !== eh) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, eh); end
      checks++;
      if (lo !== el) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, el); end
      checks++;
      if (div_by_zero !== ed) begin errors++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, ed); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    do_op(2'b11, 32'd100, 32'd7, "divu_100by7");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_neg1");
    do_op(2'b11, 32'h64, 32'd0, "divu_by_zero");
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_one_cycle: got %b expected 0", div_by_zero); end
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, "div_neg_by_zero");
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    start = 1'b1; op = 2'b01; a_in = 32'd7; b_in = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 32'd3; b_in = 32'd4;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignored_start_busy: got %b expected 1", busy); end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 20) reset = 1'b1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0 at %0d", done, i); end
    end
    do_op(2'b01, 32'd7, 32'd9, "after_abort");
    @(negedge clk);
  endtask

  task automatic test_writes();
    logic [31:0] lo_prev;
    int cyc;
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected 00001234", hi); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin errors++; $display("FAIL mthi_mtlo: got %h expected cafef00dcafef00d", {hi, lo}); end
    // lo_we while busy must be ignored.
    lo_prev = lo;
    start = 1'b1; op = 2'b01; a_in = 32'd3; b_in = 32'd4;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== lo_prev) begin errors++; $display("FAIL mtlo_busy: got %h expected %h", lo, lo_prev); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (lo !== 32'd12 || done !== 1'b1) begin errors++; $display("FAIL busy_write_result: got lo=%h done=%b expected 0000000c 1", lo, done); end
    @(negedge clk);
    // start together with lo_we: start wins.
    lo_prev = lo;
    start = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF; op = 2'b01; a_in = 32'd2; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    checks++;
    if (lo !== lo_prev || busy !== 1'b1) begin errors++; $display("FAIL start_vs_mtlo: got lo=%h busy=%b expected %h 1", lo, busy, lo_prev); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (lo !== 32'd6 || done !== 1'b1) begin errors++; $display("FAIL start_vs_mtlo_result: got lo=%h done=%b expected 00000006 1", lo, done); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_op(2'b11, 32'd1000, 32'd33, "b2b_first");
    do_op(2'b00, 32'hFFFF_F000, 32'h0001_2345, "b2b_second");
    do_op(2'b10, 32'd77, 32'hFFFF_FFF6, "b2b_third");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_writes();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative 32-bit multiply/divide unit for the MIPS datapath. It sits beside the single-cycle ALU and executes MULT, MULTU, DIV and DIVU, writing results into the architectural HI/LO registers. It also services MTHI/MTLO writes. Control stalls the pipeline using a start/busy/done handshake.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation selected by op; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  input  DATA_WIDTH  rs operand (multiplicand/dividend), sampled with start
B  input  DATA_WIDTH  rt operand (multiplier/divisor), sampled with start
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  DATA_WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO hold new results in the same cycle
div_by_zero  output  1  pulses with done when DIV/DIVU had B==0
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset).
- Reset (reset=0, any time, including mid-operation): state=IDLE, iteration counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Any in-flight operation is aborted without a result.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches A, B, op and the operand signs; counter cleared; go to RUN.
  - Exception: DIV/DIVU with B==0 goes directly to FINISH.
- RUN:
  - One iteration per cycle.
  - Multiply: shift-add on operand magnitudes, 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle on magnitudes.
  - After iteration DATA_WIDTH (counter = DATA_WIDTH-1), go to FINISH.
- FINISH (one cycle):
  - Apply sign correction.
  - Register hi/lo; done=1 for exactly the following cycle.
  - Return to IDLE.
- Latency: start sampled at edge 0 → done high after edge 33 (34 cycles). Divide-by-zero: done after edge 1.
- busy = (state != IDLE). It is registered: high from after edge 0 until after the FINISH edge. busy is low in the done cycle.
- start while busy: ignored, no queueing. start in the done cycle: accepted.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder. The remainder sign follows the dividend.
- Signed magnitude rules:
  - Magnitude of 0x80000000 is 2^31, held in a 33-bit working register. No overflow internally.
  - Result negated iff operand signs differ (product, quotient). Remainder negated iff A<0.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no flag).
- Divide by zero: lo=all ones, hi=A (unmodified), div_by_zero=1 with done. No sign correction is applied.
- MTHI/MTLO:
  - In IDLE with start=0: hi_we loads hi, lo_we loads lo on the next edge. Both may be set together.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the write is dropped.
- hi/lo hold their value at all times except on a FINISH edge or an accepted write.

Decomposition:
- Shared package/header: op encodings (MULT, MULTU, DIV, DIVU) and state encodings (IDLE, RUN, FINISH). Used by the control unit, which drives op from funct.
- One sub-module, mult_div_datapath: accumulator/remainder shift registers and add/subtract step.
- Top-level mult_div_unit: state machine, counter, sign fix-up, HI/LO registers.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → done exactly 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, busy low in the done cycle.
2. MULT A=0xFFFFFFFD (-3), B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
3. DIV A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU A=0x64, B=0 → done after 2 cycles, div_by_zero=1 for one cycle, lo=0xFFFFFFFF, hi=0x00000064.
5. Start MULTU 7×9; pulse start with other operands at cycle 5 (ignored); assert reset at cycle 10 → busy=0, hi=lo=0, no done. After release, new MULTU 7×9 → lo=63, hi=0.
6. Handshake and write rules:
   - hi_we=1, wdata=0x1234 in IDLE → hi=0x1234.
   - lo_we during busy → lo unchanged.
   - start and lo_we together → operation runs, write dropped.
   - Back-to-back start in the done cycle → accepted, second done 34 cycles later.
